// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder with a one-word holding buffer so that
// back-to-back words leave on `data` without an idle gap.
module serial_word_feeder #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_word,
    output logic             in_ready,
    output logic             data,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hb;
    logic             hb_full;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             head;
    logic [WIDTH-1:0] sh_next;

    assign accept = in_valid && in_ready;

    // Head bit and one-step advance toward the head, per bit order.
    assign head    = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    assign sh_next = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

    assign in_ready  = !hb_full;
    assign bit_valid = (state == SHIFT);
    assign data      = (state == SHIFT) ? head : IDLE_LEVEL;
    assign word_done = (state == SHIFT) && (cnt == LAST);
    assign busy      = (state == SHIFT) || hb_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            hb_full <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh    <= in_word;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        sh  <= sh_next;
                        cnt <= cnt + CW'(1);
                        if (accept) begin
                            hb      <= in_word;
                            hb_full <= 1'b1;
                        end
                    end else if (hb_full) begin
                        // Buffered word follows the last bit with no gap.
                        sh      <= hb;
                        hb_full <= 1'b0;
                        cnt     <= '0;
                    end else if (accept) begin
                        sh  <= in_word;
                        cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: an MSB-first and an LSB-first instance share
// stimulus and are compared each cycle against a word-queue model.
module tb_serial_word_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_word;

    logic rdy_m, dat_m, bv_m, wd_m, busy_m;
    logic rdy_l, dat_l, bv_l, wd_l, busy_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word),
        .in_ready(rdy_m), .data(dat_m), .bit_valid(bv_m), .word_done(wd_m), .busy(busy_m)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word),
        .in_ready(rdy_l), .data(dat_l), .bit_valid(bv_l), .word_done(wd_l), .busy(busy_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: words accepted but not yet fully sent, head word at bit `pos`.
    logic [7:0] q[$];
    int         pos   = 0;
    logic       m_acc = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                pos   = 0;
                m_acc = 1'b0;
            end else begin
                m_acc = in_valid && (q.size() < 2);
                if (q.size() > 0) begin
                    if (pos == 7) begin
                        void'(q.pop_front());
                        pos = 0;
                    end else begin
                        pos++;
                    end
                end
                if (m_acc) q.push_back(in_word);
            end
        end
    end

    // Per-cycle comparison plus collection of emitted words.
    int         cyc = 0;
    logic [7:0] col_m = '0;
    logic [7:0] col_l = '0;
    logic [7:0] got_m[$];
    logic [7:0] got_l[$];
    int         done_cyc[$];

    initial begin
        logic [7:0] cur;
        logic       act_n, e_dm, e_dl;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            act_n = (q.size() > 0);
            cur   = act_n ? q[0] : 8'h00;
            e_dm  = act_n ? cur[7 - pos] : 1'b0;
            e_dl  = act_n ? cur[pos] : 1'b0;
            check("m_data",      32'(dat_m),  32'(e_dm));
            check("l_data",      32'(dat_l),  32'(e_dl));
            check("m_bit_valid", 32'(bv_m),   32'(act_n));
            check("l_bit_valid", 32'(bv_l),   32'(act_n));
            check("m_word_done", 32'(wd_m),   32'(act_n && pos == 7));
            check("l_word_done", 32'(wd_l),   32'(act_n && pos == 7));
            check("m_busy",      32'(busy_m), 32'(act_n));
            check("l_busy",      32'(busy_l), 32'(act_n));
            check("m_in_ready",  32'(rdy_m),  32'(q.size() < 2));
            check("l_in_ready",  32'(rdy_l),  32'(q.size() < 2));
            if (bv_m) col_m = {col_m[6:0], dat_m};
            if (bv_l) col_l = {col_l[6:0], dat_l};
            if (wd_m) begin
                got_m.push_back(col_m);
                done_cyc.push_back(cyc);
            end
            if (wd_l) got_l.push_back(col_l);
        end
    end

    // Offer a word and hold in_valid until the model sees it accepted.
    task automatic send_word(input logic [7:0] w);
        int g = 0;
        in_word  = w;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            g++;
        end while (!m_acc && g < 40);
        if (!m_acc) check("accept_timeout", 32'(g), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_m[7];
        logic [7:0] exp_l[7];
        exp_m = '{8'hB4, 8'hA5, 8'h3C, 8'hF0, 8'hFF, 8'h0F, 8'h5A};
        exp_l = '{8'h2D, 8'hA5, 8'h3C, 8'h0F, 8'hFF, 8'hF0, 8'h5A};

        // Reset with a handshake offered: nothing may be accepted.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_word  = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_data",      32'(dat_m),  32'd0);
        check("rst_bit_valid", 32'(bv_m),   32'd0);
        check("rst_busy",      32'(busy_m), 32'd0);
        check("rst_in_ready",  32'(rdy_m),  32'd1);
        check("rst_word_done", 32'(wd_m),   32'd0);

        // Single word.
        send_word(8'hB4);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);

        // Back-to-back stream with in_valid held high.
        send_word(8'hA5);
        send_word(8'h3C);
        send_word(8'hF0);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);

        // New word offered exactly on the last bit of the current one.
        send_word(8'hFF);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("bypass_last_bit", 32'(wd_m), 32'd1);
        send_word(8'h0F);
        check("bypass_no_hb", 32'(rdy_m), 32'd1);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);

        // Reset mid-word with a word buffered.
        send_word(8'hC3);
        send_word(8'h81);
        in_valid = 1'b0;
        check("hb_full_ready", 32'(rdy_m), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy",      32'(busy_m), 32'd0);
        check("midrst_word_done", 32'(wd_m),   32'd0);
        check("midrst_bit_valid", 32'(bv_m),   32'd0);
        check("midrst_in_ready",  32'(rdy_m),  32'd1);
        reset = 1'b0;
        send_word(8'h5A);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);

        check("m_word_count", 32'(got_m.size()), 32'd7);
        check("l_word_count", 32'(got_l.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("m_word%0d", i), 32'(got_m.size() > i ? got_m[i] : 8'hxx), 32'(exp_m[i]));
            check($sformatf("l_word%0d", i), 32'(got_l.size() > i ? got_l[i] : 8'hxx), 32'(exp_l[i]));
        end
        if (done_cyc.size() >= 6) begin
            check("stream_gap_1", 32'(done_cyc[2] - done_cyc[1]), 32'd8);
            check("stream_gap_2", 32'(done_cyc[3] - done_cyc[2]), 32'd8);
            check("bypass_gap",   32'(done_cyc[5] - done_cyc[4]), 32'd8);
        end else begin
            check("done_pulses", 32'(done_cyc.size()), 32'd7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
